dsp_mac_signed_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate block for the DSP test designs; the next generation of the signed registered multiplier-with-accumulator. It multiplies two signed operands of configurable width, then adds the product to or subtracts it from a wide accumulator. It supports a per-sample valid qualifier, accumulator reload, sticky overflow detection and optional saturation. It maps onto one hard DSP slice plus fabric registers and is exercised by directed and random self-checking benches.

---
 rtl/dsp_mac_signed_pipe_if.sv | 23 ++
 rtl/dsp_mac_signed_pipe.sv | 91 +++++++++
 tb/tb_dsp_mac_signed_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_signed_pipe_if.sv
// dsp_mac_signed_pipe_if: sample and result bundle between a MAC source and the MAC
interface dsp_mac_signed_pipe_if #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48
);
    logic                        valid_i;
    logic                        subtract_i;
    logic                        load_i;
    logic signed [A_WIDTH-1:0]   a_i;
    logic signed [B_WIDTH-1:0]   b_i;
    logic signed [ACC_WIDTH-1:0] p_o;
    logic                        valid_o;
    logic                        overflow_o;
    modport master (
        output valid_i, subtract_i, load_i, a_i, b_i,
        input  p_o, valid_o, overflow_o
    );
    modport slave (
        input  valid_i, subtract_i, load_i, a_i, b_i,
        output p_o, valid_o, overflow_o
    );
endinterface

// File: rtl/dsp_mac_signed_pipe.sv
// dsp_mac_signed_pipe: 3-stage signed multiply-accumulate, sticky overflow; DSP_MAC_SATURATE_EN enables clamping
module dsp_mac_signed_pipe #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48
) (
    input logic                  clk,
    input logic                  reset,
    dsp_mac_signed_pipe_if.slave m
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
`ifdef DSP_MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif
    if (ACC_WIDTH < P_WIDTH) begin : g_width_check
        $error("ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    logic signed [A_WIDTH-1:0]   a_d, a_q;
    logic signed [B_WIDTH-1:0]   b_d, b_q;
    logic                        sub1_d, sub1_q, load1_d, load1_q, vld1_d, vld1_q;
    logic signed [P_WIDTH-1:0]   prod_d, prod_q;
    logic                        sub2_d, sub2_q, load2_d, load2_q, vld2_d, vld2_q;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                        vld3_d, vld3_q, ovf_d, ovf_q;
    logic signed [ACC_WIDTH-1:0] ext, base, opnd, sum;
    logic                        ovf_now;
    // S1: capture the raw sample every cycle; the valid bit qualifies it downstream
    always_comb begin
        a_d     = m.a_i;
        b_d     = m.b_i;
        sub1_d  = m.subtract_i;
        load1_d = m.load_i;
        vld1_d  = m.valid_i;
    end
    // S2: full-width signed product, control bits travel alongside
    always_comb begin
        prod_d  = P_WIDTH'(a_q) * P_WIDTH'(b_q);
        sub2_d  = sub1_q;
        load2_d = load1_q;
        vld2_d  = vld1_q;
    end
    // S3: add/subtract the product onto the accumulator (or onto 0 on load), flag signed overflow
    always_comb begin
        ext     = ACC_WIDTH'(prod_q);
        base    = load2_q ? '0 : acc_q;
        opnd    = sub2_q ? -ext : ext;
        sum     = base + opnd;
        ovf_now = (base[ACC_WIDTH-1] == opnd[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
`ifdef DSP_MAC_SATURATE_EN
        acc_d   = !vld2_q ? acc_q : ovf_now ? (base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
`else
        acc_d   = vld2_q ? sum : acc_q;
`endif
        ovf_d   = !vld2_q ? ovf_q : load2_q ? ovf_now : (ovf_q | ovf_now);
        vld3_d  = vld2_q;
    end
    // Pipeline registers; reset empties every stage and clears the accumulator and flag
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sub1_q  <= 1'b0;
            load1_q <= 1'b0;
            vld1_q  <= 1'b0;
            prod_q  <= '0;
            sub2_q  <= 1'b0;
            load2_q <= 1'b0;
            vld2_q  <= 1'b0;
            acc_q   <= '0;
            vld3_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sub1_q  <= sub1_d;
            load1_q <= load1_d;
            vld1_q  <= vld1_d;
            prod_q  <= prod_d;
            sub2_q  <= sub2_d;
            load2_q <= load2_d;
            vld2_q  <= vld2_d;
            acc_q   <= acc_d;
            vld3_q  <= vld3_d;
            ovf_q   <= ovf_d;
        end
    end
    assign m.p_o        = acc_q;
    assign m.valid_o    = vld3_q;
    assign m.overflow_o = ovf_q;
endmodule

// File: tb/tb_dsp_mac_signed_pipe.sv
// tb_dsp_mac_signed_pipe: directed and random checks of the signed MAC against an integer model
module tb_dsp_mac_signed_pipe;
    localparam int AW = 20;
    localparam int BW = 18;
    localparam int CW = 38;
    localparam longint AMAX = (longint'(1) << (CW-1)) - 1;
    localparam longint AMIN = -(longint'(1) << (CW-1));
    localparam longint SPAN = longint'(1) << CW;

    typedef struct {bit v; longint p; bit o;} exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    longint macc = 0;
    bit movf = 1'b0;
    exp_t dq[$];

    dsp_mac_signed_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) bus ();
    dsp_mac_signed_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) dut (
        .clk(clk),
        .reset(reset),
        .m(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input bit v, input bit sub, input bit ld, input longint a, input longint b);
        exp_t e;
        longint r;
        bit ov;
        if (v) begin
            r = (ld ? 0 : macc) + (sub ? -(a * b) : a * b);
            ov = (r > AMAX) || (r < AMIN);
`ifdef DSP_MAC_SATURATE_EN
            if (ov) r = (r > AMAX) ? AMAX : AMIN;
`else
            if (r > AMAX) r = r - SPAN;
            else if (r < AMIN) r = r + SPAN;
`endif
            movf = ld ? ov : (movf | ov);
            macc = r;
        end
        e.v = v;
        e.p = macc;
        e.o = movf;
        return e;
    endfunction

    task automatic tick(input bit v, input bit sub, input bit ld, input longint a, input longint b);
        exp_t x;
        bus.valid_i    = v;
        bus.subtract_i = sub;
        bus.load_i     = ld;
        bus.a_i        = AW'(a);
        bus.b_i        = BW'(b);
        dq.push_back(model(v, sub, ld, a, b));
        @(posedge clk);
        #1;
        x = dq.pop_front();
        check("model_p_o", 64'(bus.p_o), x.p);
        check("model_valid_o", 64'(bus.valid_o), 64'(x.v));
        check("model_overflow_o", 64'(bus.overflow_o), 64'(x.o));
    endtask

    task automatic bubble(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        exp_t z;
        reset          = 1'b1;
        bus.valid_i    = 1'b0;
        bus.subtract_i = 1'b0;
        bus.load_i     = 1'b0;
        bus.a_i        = '0;
        bus.b_i        = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_p_o", 64'(bus.p_o), 0);
            check("rst_valid_o", 64'(bus.valid_o), 0);
            check("rst_overflow_o", 64'(bus.overflow_o), 0);
        end
        reset = 1'b0;
        macc = 0;
        movf = 1'b0;
        z.v = 1'b0;
        z.p = 0;
        z.o = 1'b0;
        dq.delete();
        dq.push_back(z);
        dq.push_back(z);
    endtask

    initial begin
        longint ra, rb;
        int n;
        do_reset(2);
        tick(1, 0, 0, 5, 2);
        tick(1, 0, 0, 5, 2);
        bubble(1);
        check("add1_p_o", 64'(bus.p_o), 10);
        check("add1_valid_o", 64'(bus.valid_o), 1);
        bubble(1);
        check("add2_p_o", 64'(bus.p_o), 20);
        check("add2_valid_o", 64'(bus.valid_o), 1);
        tick(1, 1, 1, 5, 2);
        bubble(1);
        tick(1, 1, 0, -3, 4);
        check("load_p_o", 64'(bus.p_o), -10);
        check("load_valid_o", 64'(bus.valid_o), 1);
        bubble(1);
        check("hold_p_o", 64'(bus.p_o), -10);
        check("hold_valid_o", 64'(bus.valid_o), 0);
        bubble(1);
        check("sub_p_o", 64'(bus.p_o), 2);
        check("sub_valid_o", 64'(bus.valid_o), 1);
        tick(1, 0, 0, 7, 7);
        tick(1, 0, 0, 3, 3);
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            bubble(1);
            check("flush_valid_o", 64'(bus.valid_o), 0);
        end
        tick(1, 0, 0, 4, -6);
        bubble(2);
        check("post_rst_p_o", 64'(bus.p_o), -24);
        for (int p = 0; p < 2; p++) begin
            n = 0;
            while (n < 32) begin
                if ($urandom_range(0, 3) == 0) bubble(1);
                else begin
                    ra = longint'($urandom_range(0, 1048575)) - 524288;
                    rb = longint'($urandom_range(0, 262143)) - 131072;
                    tick(1, p[0], $urandom_range(0, 7) == 0, ra, rb);
                    n++;
                end
            end
        end
        bubble(2);
        do_reset(1);
        tick(1, 0, 0, -524288, -131072);
        tick(1, 0, 0, -524288, -131072);
        bubble(1);
        check("ovf_first_p_o", 64'(bus.p_o), longint'(1) << 36);
        check("ovf_first_flag", 64'(bus.overflow_o), 0);
        bubble(1);
`ifdef DSP_MAC_SATURATE_EN
        check("ovf_pos_p_o", 64'(bus.p_o), AMAX);
`else
        check("ovf_pos_p_o", 64'(bus.p_o), AMIN);
`endif
        check("ovf_pos_flag", 64'(bus.overflow_o), 1);
        bubble(2);
        check("ovf_sticky", 64'(bus.overflow_o), 1);
        tick(1, 0, 0, 1, 1);
        tick(1, 0, 1, 3, 3);
        bubble(1);
        check("ovf_noload_keep", 64'(bus.overflow_o), 1);
        bubble(1);
        check("ovf_load_p_o", 64'(bus.p_o), 9);
        check("ovf_load_clear", 64'(bus.overflow_o), 0);
        do_reset(1);
        repeat (3) tick(1, 0, 0, -524288, 131071);
        bubble(1);
        check("neg_pre_flag", 64'(bus.overflow_o), 0);
        bubble(1);
`ifdef DSP_MAC_SATURATE_EN
        check("neg_p_o", 64'(bus.p_o), AMIN);
`else
        check("neg_p_o", 64'(bus.p_o), (longint'(1) << 36) + 3 * (longint'(1) << 19));
`endif
        check("neg_flag", 64'(bus.overflow_o), 1);
        bubble(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
